// File: rtl/raizing_rom_pkg.sv
// raizing_rom_pkg: shared FSM state type and sizing helpers for the ROM arbiter
package raizing_rom_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    function automatic int burst_len(input int dw);
        return dw / 16;
    endfunction

    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/raizing_rr_pick.sv
// raizing_rr_pick: combinational round-robin picker, first pending channel after ptr
module raizing_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    // scan from farthest to nearest so the channel closest after ptr wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (pend[(int'(ptr) + i) % N]) begin
                idx   = W'((int'(ptr) + i) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raizing_rom_arbiter.sv
// raizing_rom_arbiter: N-channel round-robin ROM fetch arbiter onto one SDRAM bank; RAIZING_ROM_CACHE_EN keeps per-channel tags
module raizing_rom_arbiter
    import raizing_rom_pkg::*;
#(
    parameter int                     CHANNELS = 4,
    parameter int                     AW       = 22,
    parameter int                     DW       = 32,
    parameter logic [CHANNELS*AW-1:0] OFFSETS  = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [CHANNELS-1:0]    CH_CS,
    input  logic [CHANNELS*AW-1:0] CH_ADDR,
    output logic [CHANNELS-1:0]    CH_OK,
    output logic [CHANNELS*DW-1:0] CH_DOUT,
    output logic [AW-1:0]          BA_ADDR,
    output logic                   BA_RD,
    input  logic                   BA_ACK,
    input  logic                   BA_DOK,
    input  logic                   BA_RDY,
    input  logic [15:0]            DATA_READ
);

    localparam int         BL  = burst_len(DW);
    localparam int         CW  = clog2(CHANNELS);
    localparam logic [1:0] BLW = 2'(BL);

    state_t              state, nxt;
    logic [CW-1:0]       ptr, gch, pick;
    logic                pick_v, done, keep;
    logic [AW-1:0]       faddr, scaled, launch_addr;
    logic [1:0]          wcnt;
    logic [DW-1:0]       wbuf, wdata;
    logic [AW-1:0]       addr [CHANNELS];
    logic [AW-1:0]       tag  [CHANNELS];
    logic [CHANNELS-1:0] tag_v, hit, pend;

`ifndef RAIZING_ROM_CACHE_EN
    // without a cache the only valid data is what CH_OK currently advertises
    assign tag_v = CH_OK;
`endif

    assign BA_RD = (state == REQ);
    assign done  = (state == DATA) && BA_RDY;
    assign keep  = CH_CS[gch] && (addr[gch] == faddr);

    // unpack channel addresses and decide which channels need a fetch
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            addr[i] = CH_ADDR[i*AW +: AW];
            hit[i]  = tag_v[i] && (addr[i] == tag[i]);
            pend[i] = CH_CS[i] && !hit[i];
        end
    end

    raizing_rr_pick #(.N(CHANNELS), .W(CW)) u_pick (
        .pend  (pend),
        .ptr   (ptr),
        .idx   (pick),
        .valid (pick_v)
    );

    // SDRAM address of the picked channel and burst data including the word on the bus now
    always_comb begin
        scaled      = (BL == 2) ? {addr[pick][AW-2:0], 1'b0} : addr[pick];
        launch_addr = OFFSETS[int'(pick)*AW +: AW] + scaled;
        wdata       = wbuf;
        if (BA_DOK && wcnt < BLW)
            wdata[int'(wcnt)*16 +: 16] = DATA_READ;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= nxt;
    end

    // FSM next state
    always_comb begin
        nxt = state;
        if (state == IDLE && pick_v) nxt = REQ;
        if (state == REQ && BA_ACK)  nxt = DATA;
        if (done)                    nxt = IDLE;
    end

    // grant latch and burst word capture
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr     <= CW'(CHANNELS - 1);
            gch     <= '0;
            faddr   <= '0;
            BA_ADDR <= '0;
            wcnt    <= '0;
            wbuf    <= '0;
        end else begin
            if (state == IDLE && pick_v) begin
                ptr     <= pick;
                gch     <= pick;
                faddr   <= addr[pick];
                BA_ADDR <= launch_addr;
                wcnt    <= '0;
                wbuf    <= '0;
            end
            if (state == DATA && BA_DOK && wcnt < BLW) begin
                wbuf <= wdata;
                wcnt <= wcnt + 2'd1;
            end
        end
    end

    // per-channel result delivery; OK otherwise tracks whether the held data still matches
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            CH_OK   <= '0;
            CH_DOUT <= '0;
            for (int i = 0; i < CHANNELS; i++) tag[i] <= '0;
`ifdef RAIZING_ROM_CACHE_EN
            tag_v   <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (done && keep && gch == CW'(i)) begin
                    CH_OK[i]             <= 1'b1;
                    CH_DOUT[i*DW +: DW]  <= wdata;
                    tag[i]               <= faddr;
`ifdef RAIZING_ROM_CACHE_EN
                    tag_v[i]             <= 1'b1;
`endif
                end else begin
                    CH_OK[i] <= CH_CS[i] && hit[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_raizing_rom_arbiter.sv
// tb_raizing_rom_arbiter: scoreboard bench with an SDRAM responder model
module tb_raizing_rom_arbiter;

    localparam int C  = 4;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam logic [C*AW-1:0] OFFS = {22'h300000, 22'h200000, 22'h100000, 22'h000000};

    typedef struct {
        int          ch;
        logic [31:0] data;
        bit          sd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [C-1:0]    cs = '0;
    logic [C*AW-1:0] addr = '0;
    logic [C-1:0]    ok;
    logic [C*DW-1:0] dout;
    logic [AW-1:0]   ba_addr;
    logic            ba_rd;
    logic            ack = 1'b0, dok = 1'b0, rdy = 1'b0;
    logic [15:0]     rd = '0;

    int n_chk = 0, n_err = 0, cyc = 0, rdy_cyc = -10, n_req = 0, ack_dly = 0, nwords = 2, r0;
    logic [AW-1:0] last_req = '0;
    logic [AW-1:0] exp_a[$];
    exp_t          exp_q[$];
    exp_t          e;
    logic [C-1:0]  prev = '0;

    raizing_rom_arbiter #(.CHANNELS(C), .AW(AW), .DW(DW), .OFFSETS(OFFS)) dut (
        .CLK(clk), .RESET(rst_n), .CH_CS(cs), .CH_ADDR(addr), .CH_OK(ok), .CH_DOUT(dout),
        .BA_ADDR(ba_addr), .BA_RD(ba_rd), .BA_ACK(ack), .BA_DOK(dok), .BA_RDY(rdy), .DATA_READ(rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem(input logic [AW-1:0] a);
        if (a == 22'h100020) return 16'hBEEF;
        if (a == 22'h100021) return 16'hCAFE;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [AW-1:0] sd_addr(input int ch, input logic [AW-1:0] a);
        logic [C*AW-1:0] v;
        v = OFFS;
        return v[ch*AW +: AW] + {a[AW-2:0], 1'b0};
    endfunction

    function automatic logic [31:0] exp_data(input int ch, input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = sd_addr(ch, a);
        return {mem(b + 22'd1), mem(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic set_ch(input int ch, input bit c, input logic [AW-1:0] a);
        cs[ch] = c;
        addr[ch*AW +: AW] = a;
    endtask

    task automatic expect_fetch(input int ch, input logic [AW-1:0] a);
        exp_a.push_back(sd_addr(ch, a));
        exp_q.push_back('{ch, exp_data(ch, a), 1'b1});
    endtask

    task automatic wait_ok(input int ch);
        int t = 0;
        @(negedge clk);
        while (ok[ch] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("wait_ok", 64'(ok[ch]), 64'd1);
    endtask

    task automatic wait_sig(input int which);
        int t = 0;
        while (((which == 0) ? ba_rd : dok) !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk((which == 0) ? "wait_rd" : "wait_dok", 64'((which == 0) ? ba_rd : dok), 64'd1);
    endtask

    task automatic wait_req(input int n);
        int t = 0;
        while (n_req < n && t < 200) begin @(negedge clk); t++; end
        chk("wait_req", 64'(n_req >= n), 64'd1);
    endtask

    // SDRAM bank model: acks each request, returns nwords words with RDY on the last
    initial begin
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (rst_n && ba_rd) begin
                a = ba_addr;
                last_req = a;
                n_req++;
                if (exp_a.size() == 0) chk("req_queue", 64'(exp_a.size()), 64'd1);
                else chk("req_addr", 64'(a), 64'(exp_a.pop_front()));
                repeat (ack_dly) @(negedge clk);
                if (rst_n) begin
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    for (int k = 0; k < nwords; k++) begin
                        dok = 1'b1;
                        rd  = mem(a + 22'(k));
                        rdy = (k == nwords - 1);
                        if (rdy) rdy_cyc = cyc;
                        @(negedge clk);
                    end
                    dok = 1'b0;
                    rdy = 1'b0;
                end
            end
        end
    end

    // completion monitor: every rising CH_OK must match the next expected result
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < C; i++) begin
                if (ok[i] && !prev[i]) begin
                    if (exp_q.size() == 0) chk("ok_queue", 64'(exp_q.size()), 64'd1);
                    else begin
                        e = exp_q.pop_front();
                        chk("ok_ch", 64'(i), 64'(e.ch));
                        chk("dout", 64'(dout[i*DW +: DW]), 64'(e.data));
                        if (e.sd) chk("ok_lat", 64'(cyc), 64'(rdy_cyc + 1));
                    end
                end
            end
        end
        prev = ok;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd", 64'(ba_rd), 64'd0);
        chk("rst_addr", 64'(ba_addr), 64'd0);
        chk("rst_ok", 64'(ok), 64'd0);
        chk("rst_dout", 64'(dout[63:0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single fetch on channel 1
        expect_fetch(1, 22'h10);
        set_ch(1, 1'b1, 22'h10);
        wait_ok(1);
        chk("t1_ba", 64'(last_req), 64'h100020);
        chk("t1_dout", 64'(dout[63:32]), 64'hCAFEBEEF);
        set_ch(1, 1'b0, 22'h10);
        @(negedge clk);
        chk("t1_stale", 64'(ok[1]), 64'd0);

        // round robin from reset, with surplus words per burst
        rst_n = 1'b0;
        nwords = 3;
        for (int ch = 0; ch < C; ch++) begin
            set_ch(ch, 1'b1, 22'(32'h20 + ch));
            expect_fetch(ch, 22'(32'h20 + ch));
        end
        expect_fetch(0, 22'h30);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ok(2);
        wait_sig(0);
        set_ch(0, 1'b1, 22'h30);
        wait_ok(3);
        wait_ok(0);
        nwords = 2;

        // address change while channel 2 is in DATA
        r0 = n_req;
        exp_a.push_back(sd_addr(2, 22'h5));
        set_ch(2, 1'b1, 22'h5);
        wait_sig(1);
        set_ch(2, 1'b1, 22'h6);
        expect_fetch(2, 22'h6);
        wait_req(r0 + 2);
        chk("t3_disc", 64'(ok[2]), 64'd0);
        wait_ok(2);

        // cache hit after CS gap
        for (int ch = 1; ch < C; ch++) cs[ch] = 1'b0;
        expect_fetch(0, 22'h40);
        set_ch(0, 1'b1, 22'h40);
        wait_ok(0);
        set_ch(0, 1'b0, 22'h40);
        repeat (3) @(negedge clk);
        chk("t4_drop", 64'(ok[0]), 64'd0);
        r0 = n_req;
        set_ch(0, 1'b1, 22'h40);
`ifdef RAIZING_ROM_CACHE_EN
        exp_q.push_back('{0, exp_data(0, 22'h40), 1'b0});
        @(negedge clk);
        chk("t4_hit", 64'(ok[0]), 64'd1);
        repeat (10) @(negedge clk);
        chk("t4_norq", 64'(n_req), 64'(r0));
`else
        expect_fetch(0, 22'h40);
        wait_ok(0);
        chk("t4_refetch", 64'(n_req), 64'(r0 + 1));
`endif

        // reset while a request is outstanding
        exp_a.push_back(sd_addr(2, 22'h50));
        ack_dly = 3;
        set_ch(2, 1'b1, 22'h50);
        set_ch(3, 1'b1, 22'h60);
        wait_sig(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rd", 64'(ba_rd), 64'd0);
        chk("t5_ok", 64'(ok), 64'd0);
        ack_dly = 0;
        repeat (5) @(negedge clk);
        expect_fetch(0, 22'h40);
        expect_fetch(2, 22'h50);
        expect_fetch(3, 22'h60);
        rst_n = 1'b1;
        wait_ok(3);
        repeat (5) @(negedge clk);
        chk("q_req_left", 64'(exp_a.size()), 64'd0);
        chk("q_data_left", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
